window3x3_gen: RTL and testbench

//   Streaming 3x3 window generator sitting directly upstream of the 9-lane scalar multiplier array.

---
 rtl/window3x3_pkg.sv | 25 ++
 rtl/window3x3_gen_line_buf.sv | 27 ++
 rtl/window3x3_gen.sv | 132 +++++++++++++
 tb/tb_window3x3_gen.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/window3x3_pkg.sv
// Shared types, window lane indices and counter-width helpers for the 3x3 window generator.
package window3x3_pkg;

  localparam int DW_DEF = 8;

  typedef logic [DW_DEF-1:0] pix_t;

  // Row-major lane indices: T/M/B = rows r-2/r-1/r, L/C/R = cols c-2/c-1/c
  localparam int WIN_TL = 0;
  localparam int WIN_TC = 1;
  localparam int WIN_TR = 2;
  localparam int WIN_ML = 3;
  localparam int WIN_MC = 4;
  localparam int WIN_MR = 5;
  localparam int WIN_BL = 6;
  localparam int WIN_BC = 7;
  localparam int WIN_BR = 8;
  localparam int WIN_N  = 9;

  // Width of a counter spanning 0..n-1, never narrower than one bit
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/window3x3_gen_line_buf.sv
// One-line pixel store: a single read+write port at the same address, returning the old contents
// in the same cycle that the new pixel is written (read-before-write).
module line_buf
  import window3x3_pkg::*;
#(
  parameter  int DEPTH = 64,
  parameter  int DW    = DW_DEF,
  localparam int AW    = cnt_w(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  assign rdata = mem[addr];

  // NOTE: storage arrays are deliberately left out of reset so they map onto plain RAM; any stale
  // contents are masked upstream by the row gate.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

endmodule

// File: rtl/window3x3_gen.sv
// Streaming 3x3 "valid" window generator over a raster pixel stream.
// Optional SOF_SYNC_EN adds pix_sof, which forces the accepted pixel to be (0,0).
module window3x3_gen
  import window3x3_pkg::*;
#(
  parameter int IMG_W = 64,
  parameter int IMG_H = 64,
  parameter int DW    = DW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] pix_data,
  input  logic          pix_valid,
  output logic          pix_ready,
`ifdef SOF_SYNC_EN
  input  logic          pix_sof,
`endif
  output logic [DW-1:0] win0,
  output logic [DW-1:0] win1,
  output logic [DW-1:0] win2,
  output logic [DW-1:0] win3,
  output logic [DW-1:0] win4,
  output logic [DW-1:0] win5,
  output logic [DW-1:0] win6,
  output logic [DW-1:0] win7,
  output logic [DW-1:0] win8,
  output logic          win_valid,
  input  logic          win_ready,
  output logic          frame_done
);

  localparam int CW = cnt_w(IMG_W);
  localparam int RW = cnt_w(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  logic [CW-1:0] col_q, col_cur;
  logic [RW-1:0] row_q, row_cur;
  logic          accept;
  logic          col_last, row_last, win_gate;
  logic [DW-1:0] up1, up2;
  logic [DW-1:0] win_q [WIN_N];

  assign pix_ready = ~win_valid | win_ready;
  assign accept    = pix_valid & pix_ready;

  // NOTE: every signal written in a combinational block gets a default first so no latch is inferred.
  always_comb begin
    col_cur = col_q;
    row_cur = row_q;
`ifdef SOF_SYNC_EN
    if (pix_sof) begin
      col_cur = '0;
      row_cur = '0;
    end
`endif
  end

  assign col_last = (col_cur == COL_LAST);
  assign row_last = (row_cur == ROW_LAST);
  assign win_gate = (row_cur >= RW'(2)) && (col_cur >= CW'(2));

  // lb0 holds line r-1; its old word cascades into lb1, which holds line r-2
  line_buf #(.DEPTH(IMG_W), .DW(DW)) u_lb0 (
    .clk   (clk),
    .we    (accept),
    .addr  (col_cur),
    .wdata (pix_data),
    .rdata (up1)
  );

  line_buf #(.DEPTH(IMG_W), .DW(DW)) u_lb1 (
    .clk   (clk),
    .we    (accept),
    .addr  (col_cur),
    .wdata (up1),
    .rdata (up2)
  );

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q <= '0;
      row_q <= '0;
    end else if (accept) begin
      if (col_last) begin
        col_q <= '0;
        row_q <= row_last ? '0 : row_cur + RW'(1);
      end else begin
        col_q <= col_cur + CW'(1);
        row_q <= row_cur;
      end
    end
  end

  // Window columns shift left; the new right column is {(r-2,c),(r-1,c),(r,c)}
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < WIN_N; i++) win_q[i] <= '0;
    end else if (accept) begin
      for (int r = 0; r < 3; r++) begin
        win_q[3*r]     <= win_q[3*r + 1];
        win_q[3*r + 1] <= win_q[3*r + 2];
      end
      win_q[WIN_TR] <= up2;
      win_q[WIN_MR] <= up1;
      win_q[WIN_BR] <= pix_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_valid  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= accept & col_last & row_last;
      if (accept)         win_valid <= win_gate;
      else if (win_ready) win_valid <= 1'b0;
    end
  end

  assign win0 = win_q[WIN_TL];
  assign win1 = win_q[WIN_TC];
  assign win2 = win_q[WIN_TR];
  assign win3 = win_q[WIN_ML];
  assign win4 = win_q[WIN_MC];
  assign win5 = win_q[WIN_MR];
  assign win6 = win_q[WIN_BL];
  assign win7 = win_q[WIN_BC];
  assign win8 = win_q[WIN_BR];

endmodule

// File: tb/tb_window3x3_gen.sv
// Directed self-checking bench: a 4x4 instance for frame/stall/reset/sync tests, a 3x3 instance
// for the minimum-size frame.
module tb_window3x3_gen;
  import window3x3_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // 4x4 instance
  pix_t pd4 = '0;
  logic pv4 = 1'b0, wr4 = 1'b1, sof4 = 1'b0;
  logic prdy4, wv4, fd4;
  pix_t a0, a1, a2, a3, a4, a5, a6, a7, a8;
  logic [71:0] win4_pk;
  assign win4_pk = {a0, a1, a2, a3, a4, a5, a6, a7, a8};

  // 3x3 instance
  pix_t pd3 = '0;
  logic pv3 = 1'b0, wr3 = 1'b1;
  logic prdy3, wv3, fd3;
  pix_t b0, b1, b2, b3, b4, b5, b6, b7, b8;
  logic [71:0] win3_pk;
  assign win3_pk = {b0, b1, b2, b3, b4, b5, b6, b7, b8};

  window3x3_gen #(.IMG_W(4), .IMG_H(4), .DW(8)) dut4 (
    .clk(clk), .rst_n(rst_n), .pix_data(pd4), .pix_valid(pv4), .pix_ready(prdy4),
`ifdef SOF_SYNC_EN
    .pix_sof(sof4),
`endif
    .win0(a0), .win1(a1), .win2(a2), .win3(a3), .win4(a4), .win5(a5), .win6(a6), .win7(a7),
    .win8(a8), .win_valid(wv4), .win_ready(wr4), .frame_done(fd4)
  );

  window3x3_gen #(.IMG_W(3), .IMG_H(3), .DW(8)) dut3 (
    .clk(clk), .rst_n(rst_n), .pix_data(pd3), .pix_valid(pv3), .pix_ready(prdy3),
`ifdef SOF_SYNC_EN
    .pix_sof(1'b0),
`endif
    .win0(b0), .win1(b1), .win2(b2), .win3(b3), .win4(b4), .win5(b5), .win6(b6), .win7(b7),
    .win8(b8), .win_valid(wv3), .win_ready(wr3), .frame_done(fd3)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Window transfers and frame_done pulses, sampled mid-cycle
  logic [71:0] q4[$];
  logic [71:0] q3[$];
  int fd4_cnt = 0, fd3_cnt = 0, fd_orphan = 0;

  always @(negedge clk) begin
    if (wv4 && wr4) q4.push_back(win4_pk);
    if (wv3 && wr3) q3.push_back(win3_pk);
    if (fd4) begin fd4_cnt++; if (!wv4) fd_orphan++; end
    if (fd3) begin fd3_cnt++; if (!wv3) fd_orphan++; end
  end

  // Expected window centred-bottom-right at (r,c) for pixel value base + r*w + c + 1
  function automatic logic [71:0] exp_win(input int base, input int w, input int r, input int c);
    logic [71:0] res = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        res = {res[63:0], 8'(base + (r - 2 + i) * w + (c - 2 + j) + 1)};
    return res;
  endfunction

  task automatic send4(input int v, input bit sof);
    bit ok = 1'b0;
    pd4 = 8'(v); pv4 = 1'b1; sof4 = sof;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (prdy4) begin ok = 1'b1; break; end
    end
    if (!ok) check("send4_timeout", 0, 1);
    @(posedge clk); #1;
    pv4 = 1'b0; sof4 = 1'b0;
  endtask

  task automatic send3(input int v);
    bit ok = 1'b0;
    pd3 = 8'(v); pv3 = 1'b1;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (prdy3) begin ok = 1'b1; break; end
    end
    if (!ok) check("send3_timeout", 0, 1);
    @(posedge clk); #1;
    pv3 = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_obs();
    q4.delete(); q3.delete();
    fd4_cnt = 0; fd3_cnt = 0;
  endtask

  // Compare q4 against the four windows of one 4x4 frame starting at q4[off]
  task automatic check_frame4(input string tag, input int off, input int base);
    int k = off;
    for (int r = 2; r < 4; r++)
      for (int c = 2; c < 4; c++) begin
        if (k < q4.size()) check($sformatf("%s_win%0d", tag, k), q4[k], exp_win(base, 4, r, c));
        else check($sformatf("%s_missing%0d", tag, k), 0, 1);
        k++;
      end
  endtask

  initial begin
    // Reset state
    #2;
    check("rst_win_valid", wv4, 0);
    check("rst_win", win4_pk, 0);
    check("rst_frame_done", fd4, 0);
    check("rst_pix_ready", prdy4, 1);
    @(posedge clk); #1; rst_n = 1'b1;
    idle(2);

    // Test 1: one 4x4 frame at full throughput
    clear_obs();
    for (int v = 1; v <= 16; v++) send4(v, 1'b0);
    idle(3);
    check("t1_count", q4.size(), 4);
    check_frame4("t1", 0, 0);
    check("t1_frame_done", fd4_cnt, 1);

    // Test 2: stall the first window for five cycles
    clear_obs();
    wr4 = 1'b0;
    for (int v = 1; v <= 11; v++) send4(v, 1'b0);
    pd4 = 8'd12; pv4 = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("t2_hold_valid", wv4, 1);
      check("t2_hold_ready", prdy4, 0);
      check("t2_hold_win", win4_pk, exp_win(0, 4, 2, 2));
    end
    @(posedge clk); #1; wr4 = 1'b1;
    for (int v = 12; v <= 16; v++) send4(v, 1'b0);
    idle(3);
    check("t2_count", q4.size(), 4);
    check_frame4("t2", 0, 0);
    check("t2_frame_done", fd4_cnt, 1);

    // Test 3: two frames back-to-back
    clear_obs();
    for (int v = 1; v <= 16; v++) send4(v, 1'b0);
    for (int v = 101; v <= 116; v++) send4(v, 1'b0);
    idle(3);
    check("t3_count", q4.size(), 8);
    check_frame4("t3a", 0, 0);
    check_frame4("t3b", 4, 100);
    check("t3_frame_done", fd4_cnt, 2);

    // Test 4: minimum 3x3 frame, then two lines of the next frame yield nothing
    clear_obs();
    for (int v = 1; v <= 9; v++) send3(v);
    idle(2);
    check("t4_count1", q3.size(), 1);
    if (q3.size() > 0) check("t4_win", q3[0], exp_win(0, 3, 2, 2));
    check("t4_frame_done", fd3_cnt, 1);
    for (int v = 11; v <= 16; v++) send3(v);
    idle(2);
    check("t4_quiet", q3.size(), 1);
    for (int v = 17; v <= 19; v++) send3(v);
    idle(2);
    check("t4_count2", q3.size(), 2);
    if (q3.size() > 1) check("t4_win2", q3[1], exp_win(10, 3, 2, 2));

    // Test 5: reset mid-frame, then a clean frame
    for (int v = 1; v <= 7; v++) send4(v, 1'b0);
    rst_n = 1'b0;
    #2;
    check("t5_rst_valid", wv4, 0);
    check("t5_rst_win", win4_pk, 0);
    check("t5_rst_frame_done", fd4, 0);
    @(posedge clk); #1; rst_n = 1'b1;
    idle(1);
    clear_obs();
    for (int v = 1; v <= 16; v++) send4(v, 1'b0);
    idle(3);
    check("t5_count", q4.size(), 4);
    check_frame4("t5", 0, 0);
    check("t5_frame_done", fd4_cnt, 1);

`ifdef SOF_SYNC_EN
    // Test 6: partial frame dropped by start-of-frame
    clear_obs();
    for (int v = 1; v <= 6; v++) send4(v, 1'b0);
    for (int v = 1; v <= 16; v++) send4(v, v == 1);
    idle(3);
    check("t6_count", q4.size(), 4);
    check_frame4("t6", 0, 0);
    check("t6_frame_done", fd4_cnt, 1);
`endif

    check("frame_done_with_window", fd_orphan, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
